riscv_mmio_responder: RTL



---
 rtl/riscv_mmio_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/riscv_mmio_responder.sv
// riscv_mmio_responder
//   Answers CPU data-bus load/store requests that fall in a 16-byte MMIO
//   window: a console TX FIFO drained over a valid/ready character port,
//   a STATUS word, a sticky tohost halt/exit-code register and a
//   free-running cycle counter that freezes on halt.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (accept on valid && ready)
//   req_write, req_addr,
//   req_wdata, req_wstrb         request payload
//   resp_valid, resp_rdata,
//   resp_err                     single-cycle response, one cycle after accept
//   char_valid/char_ready,
//   char_data                    console byte stream (FIFO head)
//   halted, exit_code            tohost halt flag and tohost[31:1]
module riscv_mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        halted,
  output logic [30:0] exit_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] SEL_TX     = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_TOHOST = 2'd2;
  localparam logic [1:0] SEL_CYCLE  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr, count;
  logic          full, empty, pop, push;
  logic          bad_p0, accept_p0, tx_store_p0, halt_set_p0;
  logic [1:0]    sel_p0;
  logic [31:0]   rdata_p0;
  logic [31:0]   cycle_cnt;
  logic          unused_wstrb;

  function automatic logic [31:0] status_word(input logic f, input logic e,
                                              input logic [PW-1:0] c);
    return {22'b0, f, e, 8'(c)};
  endfunction

  assign unused_wstrb = ^req_wstrb[3:1];

  // Request decode stage (combinational, pre-edge state)
  assign sel_p0      = req_addr[3:2];
  assign bad_p0      = (req_addr[31:4] != BASE_ADDR[31:4]) || (req_addr[1:0] != 2'b00);
  assign count       = wptr - rptr;
  assign full        = (count == PW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign char_valid  = !empty;
  assign char_data   = mem[rptr[AW-1:0]];
  assign pop         = char_valid && char_ready;

  // After halt, TX stores are acknowledged without effect, so they never stall.
  assign tx_store_p0 = req_write && !bad_p0 && (sel_p0 == SEL_TX) && req_wstrb[0] && !halted;
  assign req_ready   = !(req_valid && tx_store_p0 && full && !pop);
  assign accept_p0   = req_valid && req_ready;
  assign push        = accept_p0 && tx_store_p0;
  assign halt_set_p0 = accept_p0 && req_write && !bad_p0 && (sel_p0 == SEL_TOHOST) &&
                       req_wdata[0] && !halted;

  always_comb begin
    rdata_p0 = 32'h0;
    if (!req_write && !bad_p0) begin
      case (sel_p0)
        SEL_STATUS: rdata_p0 = status_word(full, empty, count);
        SEL_TOHOST: rdata_p0 = {exit_code, halted};
        SEL_CYCLE:  rdata_p0 = cycle_cnt;
        default:    rdata_p0 = 32'h0;
      endcase
    end
  end

  // Response stage (_p1): registered one cycle after acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= accept_p0;
      if (accept_p0) begin
        resp_rdata <= rdata_p0;
        resp_err   <= bad_p0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= req_wdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halted    <= 1'b0;
      exit_code <= 31'h0;
    end else if (halt_set_p0) begin
      halted    <= 1'b1;
      exit_code <= req_wdata[31:1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)        cycle_cnt <= 32'h0;
    else if (!halted) cycle_cnt <= cycle_cnt + 32'h1;
  end

endmodule
